// File: rtl/ahb_decode_mux.sv
// AHB address decoder and response multiplexor for NSLAVES slaves with a built-in ERROR default slave.
// Define AHB_DECODE_TIMEOUT_EN to turn a stalled slave into an ERROR response after TIMEOUT_CYCLES wait states.
module ahb_decode_mux #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NSLAVES        = 4,
    parameter int REGION_BITS    = 12,
    parameter int SEL_BITS       = (NSLAVES > 1) ? $clog2(NSLAVES) : 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         haddr,
    input  logic [1:0]                    htrans,
    output logic [NSLAVES-1:0]            selx,
    output logic                          master_ready,
    output logic                          master_resp,
    output logic [DATA_WIDTH-1:0]         master_rdata,
    input  logic [NSLAVES-1:0]            slaves_ready,
    input  logic [NSLAVES-1:0]            slaves_resp,
    input  logic [NSLAVES*DATA_WIDTH-1:0] slaves_rdata
);

    localparam int TOP_LSB = REGION_BITS + SEL_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t                r_state;
    logic [SEL_BITS-1:0]   r_dsel;

    logic [SEL_BITS-1:0]   w_idx;
    logic                  w_hi_zero;
    logic                  w_mapped;
    logic                  w_s_rdy;
    logic                  w_s_resp;
    logic [DATA_WIDTH-1:0] w_s_rdata;
    logic                  w_unused;

    // Address-phase decode
    assign w_idx    = haddr[REGION_BITS +: SEL_BITS];
    assign w_unused = ^{haddr[REGION_BITS-1:0], htrans[0]};

    generate
        if (TOP_LSB < ADDR_WIDTH) begin : g_hi_bits
            assign w_hi_zero = (haddr[ADDR_WIDTH-1:TOP_LSB] == '0);
        end else begin : g_no_hi_bits
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    assign w_mapped = w_hi_zero && (32'(w_idx) < NSLAVES);

    always_comb begin
        selx = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            selx[k] = w_mapped && (32'(w_idx) == k);
        end
    end

    // Data-phase response steering from the registered owner
    always_comb begin
        w_s_rdy   = 1'b0;
        w_s_resp  = 1'b0;
        w_s_rdata = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (32'(r_dsel) == k) begin
                w_s_rdy   = slaves_ready[k];
                w_s_resp  = slaves_resp[k];
                w_s_rdata = slaves_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        master_ready = 1'b1;
        master_resp  = 1'b0;
        master_rdata = '0;
        case (r_state)
            ST_FWD: begin
                master_ready = w_s_rdy;
                master_resp  = w_s_resp;
                master_rdata = w_s_rdata;
            end
            ST_ERR1: begin
                master_ready = 1'b0;
                master_resp  = 1'b1;
            end
            ST_ERR2: begin
                master_resp  = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef AHB_DECODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tmo_hit;

    assign w_cnt_next = r_tmo_cnt + 1'b1;
    assign w_tmo_hit  = (r_state == ST_FWD) && !w_s_rdy && (32'(w_cnt_next) == TIMEOUT_CYCLES);
`endif

    // Control state: owner capture on ready edges, two-cycle error sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dsel  <= '0;
`ifdef AHB_DECODE_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            if (master_ready) begin
                r_dsel <= w_idx;
                if (htrans[1] && w_mapped) begin
                    r_state <= ST_FWD;
                end else if (htrans[1]) begin
                    r_state <= ST_ERR1;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else if (r_state == ST_ERR1) begin
                r_state <= ST_ERR2;
`ifdef AHB_DECODE_TIMEOUT_EN
            end else if (w_tmo_hit) begin
                r_state <= ST_ERR1;
`endif
            end

`ifdef AHB_DECODE_TIMEOUT_EN
            // Counter holds at the limit through ERR1 and clears on the ERR2 ready edge
            if (master_ready) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_FWD) begin
                r_tmo_cnt <= w_cnt_next;
            end
`endif
        end
    end

endmodule

// File: doc/ahb_decode_mux.md
Name: ahb_decode_mux

Overview:
- Parametrised AHB interconnect core: merges address decoder and response multiplexor into one block for N slaves.
- Decodes the address-phase address to a one-hot select.
- Registers the data-phase owner and steers the owning slave's ready/resp/rdata back to the master.
- Built-in default slave returns the two-cycle AHB ERROR response for unmapped active transfers.
- Sits between the single AHB master and the slave devices on the system bus.

Parameters:
- ADDR_WIDTH, 32, address bus width (matches AHB_ADDR_WIDTH).
- DATA_WIDTH, 32, data bus width (matches AHB_DATA_WIDTH).
- NSLAVES, 4, number of slaves, 1..16.
- REGION_BITS, 12, log2 of each slave's region size in bytes; slave k owns [k<<REGION_BITS, (k+1)<<REGION_BITS).
- SEL_BITS, $clog2(NSLAVES) (minimum 1), width of the slave index field.
- TIMEOUT_CYCLES, 16, wait-state limit used only when the optional feature is enabled; minimum 2.

Ports:
- clk  in  1  bus clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- haddr  in  ADDR_WIDTH  master address.
- htrans  in  2  master transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- selx  out  NSLAVES  one-hot slave select, combinational from haddr.
- master_ready  out  1  HREADY to master; also broadcast to all slaves as HREADYIN.
- master_resp  out  1  0 OKAY, 1 ERROR.
- master_rdata  out  DATA_WIDTH  read data to master.
- slaves_ready  in  NSLAVES  per-slave HREADYOUT.
- slaves_resp  in  NSLAVES  per-slave response.
- slaves_rdata  in  NSLAVES*DATA_WIDTH  packed slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Decode (combinational)
  - idx = haddr[REGION_BITS +: SEL_BITS].
  - mapped = (haddr bits above REGION_BITS+SEL_BITS all zero) AND idx < NSLAVES.
  - selx = mapped ? (1<<idx) : 0. selx does not depend on htrans.
- Data-phase capture (only on a clock edge where master_ready=1)
  - dsel <= idx.
  - dact <= htrans[1] & mapped.
  - derr <= htrans[1] & ~mapped.
  - IDLE/BUSY transfers capture dact=0 and derr=0.
- States:
  - IDLE: dact=0, derr=0.
  - FWD: dact=1.
  - ERR1, ERR2: default-slave error response.
- Outputs per state:
  - IDLE: master_ready=1, master_resp=0, master_rdata=0.
  - FWD: master_ready, master_resp and master_rdata = slaves_ready[dsel], slaves_resp[dsel] and slice dsel of slaves_rdata; combinational, zero added latency.
  - ERR1: master_ready=0, master_resp=1, master_rdata=0.
  - ERR2: master_ready=1, master_resp=1, master_rdata=0.
- Transitions:
  - An edge with master_ready=1 moves to FWD, ERR1 or IDLE, set by the captured dact/derr.
  - ERR1 always moves to ERR2.
  - ERR2 acts as a ready cycle: it captures the next address phase like any other.
  - FWD holds while slaves_ready[dsel]=0.
- Pipelining: back-to-back transfers to different slaves are supported; the address phase of transfer n+1 overlaps the data phase of transfer n. Every slave sees HREADYIN = master_ready.
- Reset (rst=1 at an edge): state IDLE, dsel=0, dact=0, derr=0, timeout counter=0. The following cycle shows master_ready=1, master_resp=0, master_rdata=0.
- Reset mid-transfer: any in-flight data phase is abandoned and no error is signalled.
- Boundaries:
  - Highest mapped address, ((NSLAVES<<REGION_BITS)-1), selects slave NSLAVES-1.
  - The next address, NSLAVES<<REGION_BITS, is unmapped.
  - With NSLAVES=1, SEL_BITS=1 and idx=1 is unmapped.

Optional Feature:
- Macro: AHB_DECODE_TIMEOUT_EN.
- Enabled:
  - A counter increments on each FWD cycle with slaves_ready[dsel]=0 and clears on any ready cycle.
  - When it reaches TIMEOUT_CYCLES, the next state is ERR1, then ERR2: a standard ERROR response to the master.
  - The stalled slave's outputs are ignored from ERR1 onward.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Disabled: no counter is instantiated; FWD waits indefinitely.

Test Plan:
- Reset: assert rst 2 cycles -> master_ready=1, master_resp=0, master_rdata=0, selx=0 for haddr=0x0001_0000.
- Read NONSEQ haddr=0x0000_2004, slave 2 ready=1, rdata=0xA5A5_0002 -> selx=4'b0100; next cycle master_rdata=0xA5A5_0002, master_resp=0, master_ready=1.
- Pipeline: NONSEQ to 0x1000, then 0x3000 on consecutive cycles; slave 1 adds 2 wait states -> master_ready low exactly 2 cycles; slave 3 data appears only after slave 1 completes.
- Unmapped: NONSEQ haddr=0x0000_5000 -> cycle+1 ready=0 resp=1; cycle+2 ready=1 resp=1; IDLE to same address gives ready=1 resp=0.
- Timeout (TIMEOUT_CYCLES=4, macro on): slave 0 holds ready=0 -> 4 stall cycles, then ERR1/ERR2; a late ready from slave 0 is ignored. With the macro off, the stall persists 20 cycles.
- Reset mid-wait: rst during a slave 1 stall -> next cycle IDLE outputs, and a following NONSEQ to 0x0000 completes normally.
